// File: rtl/fft8_frame_loader.sv
// Ping-pong frame loader in front of the 8-point FFT core: packs a serial complex
// sample stream into 8-slot banks and hands each full bank over in parallel.
module fft8_frame_loader #(
    parameter int W     = 9,
    parameter bit BITREV = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [W-1:0]       s_re,
    input  logic [W-1:0]       s_im,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [8*W-1:0]     m_re,
    output logic [8*W-1:0]     m_im,
    output logic               frame_err,
    output logic [CNT_W-1:0]   frame_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [W-1:0] bank_re [2][8];
    logic [W-1:0] bank_im [2][8];
    logic [1:0]   full;
    logic         wr_bank;
    logic         rd_bank;
    logic [2:0]   wr_idx;

    logic         accept;
    logic         handoff;
    logic [2:0]   slot;

    // Readiness looks only at the write bank, never at m_ready, so a bank being
    // released this cycle is not refilled until the next one.
    assign s_ready = !rst && !full[wr_bank];
    assign m_valid = !rst && full[rd_bank];
    assign accept  = s_valid && s_ready;
    assign handoff = m_valid && m_ready;
    assign slot    = BITREV ? {wr_idx[0], wr_idx[1], wr_idx[2]} : wr_idx;

    always_comb begin
        m_re = '0;
        m_im = '0;
        for (int j = 0; j < 8; j++) begin
            m_re[W*j +: W] = bank_re[rd_bank][j];
            m_im[W*j +: W] = bank_im[rd_bank][j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= 3'd0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int j = 0; j < 8; j++) begin
                    bank_re[b][j] <= '0;
                    bank_im[b][j] <= '0;
                end
            end
        end else begin
            frame_err <= 1'b0;
            // Hand-off and completion always touch different banks.
            if (handoff) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
                frame_cnt     <= frame_cnt + CNT_ONE;
            end
            if (accept) begin
                bank_re[wr_bank][slot] <= s_re;
                bank_im[wr_bank][slot] <= s_im;
                if (wr_idx == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_idx        <= 3'd0;
                    frame_err     <= !s_last;
                end else if (s_last) begin
                    wr_idx    <= 3'd0;
                    frame_err <= 1'b1;
                end else begin
                    wr_idx <= wr_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Scoreboard bench for fft8_frame_loader: a frame-level model builds expected frames
// from accepted samples, a negedge monitor checks both the natural- and bit-reversed-order DUTs.
module tb_fft8_frame_loader;

    localparam int W     = 9;
    localparam int CNT_W = 4;
    localparam int FW    = 8 * W;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         last;
    } samp_t;

    typedef struct packed {
        logic [FW-1:0] re;
        logic [FW-1:0] im;
    } frame_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic [W-1:0]     s_re = '0;
    logic [W-1:0]     s_im = '0;
    logic             s_last = 1'b0;
    logic             m_ready = 1'b0;

    logic             s_ready0, m_valid0, frame_err0;
    logic [FW-1:0]    m_re0, m_im0;
    logic [CNT_W-1:0] frame_cnt0;
    logic             s_ready1, m_valid1, frame_err1;
    logic [FW-1:0]    m_re1, m_im1;
    logic [CNT_W-1:0] frame_cnt1;

    fft8_frame_loader #(.W(W), .BITREV(1'b0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0),
        .s_re(s_re), .s_im(s_im), .s_last(s_last),
        .m_valid(m_valid0), .m_ready(m_ready), .m_re(m_re0), .m_im(m_im0),
        .frame_err(frame_err0), .frame_cnt(frame_cnt0)
    );

    fft8_frame_loader #(.W(W), .BITREV(1'b1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1),
        .s_re(s_re), .s_im(s_im), .s_last(s_last),
        .m_valid(m_valid1), .m_ready(m_ready), .m_re(m_re1), .m_im(m_im1),
        .frame_err(frame_err1), .frame_cnt(frame_cnt1)
    );

    always #5 clk = ~clk;

    samp_t            stim[$];
    samp_t            part[$];
    frame_t           exp_q[$];
    int               held = 0;
    int               n_vec = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             exp_err = 1'b0;
    bit               acc_last = 1'b0;
    int               mr_mode = 0;
    bit               gaps = 1'b0;

    function automatic int brev(int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    task automatic chk(string name, logic [FW-1:0] act, logic [FW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_samp(int re, int im, bit last);
        samp_t s;
        s.re   = re[W-1:0];
        s.im   = im[W-1:0];
        s.last = last;
        stim.push_back(s);
    endtask

    // Reference model: frame-level view of the stream, updated at each active edge.
    always @(posedge clk) begin
        bit     rdy;
        bit     hand;
        samp_t  s;
        frame_t f;
        rdy      = !rst && (held < 2);
        hand     = !rst && (held > 0) && m_ready;
        acc_last = rdy && s_valid;
        if (rst) begin
            exp_q.delete();
            part.delete();
            held    = 0;
            exp_cnt = '0;
            exp_err = 1'b0;
        end else begin
            if (hand) begin
                held--;
                exp_cnt = exp_cnt + 1'b1;
            end
            exp_err = 1'b0;
            if (acc_last) begin
                s.re   = s_re;
                s.im   = s_im;
                s.last = s_last;
                part.push_back(s);
                if (part.size() == 8) begin
                    for (int k = 0; k < 8; k++) begin
                        f.re[W*k +: W] = part[k].re;
                        f.im[W*k +: W] = part[k].im;
                    end
                    exp_q.push_back(f);
                    held++;
                    exp_err = !s_last;
                    part.delete();
                end else if (s_last) begin
                    part.delete();
                    exp_err = 1'b1;
                end
            end
        end
    end

    // Driver: holds each sample until the model sees it accepted.
    always @(posedge clk) begin
        samp_t s;
        #1;
        if (acc_last && stim.size() > 0) s = stim.pop_front();
        if (!(s_valid && !acc_last && stim.size() > 0)) begin
            s_valid = (stim.size() > 0) && !(gaps && $urandom_range(3) == 0);
        end
        if (s_valid) begin
            s_re   = stim[0].re;
            s_im   = stim[0].im;
            s_last = stim[0].last;
        end else begin
            s_re   = W'($urandom);
            s_im   = W'($urandom);
            s_last = $urandom_range(1) == 1;
        end
        case (mr_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = $urandom_range(1) == 1;
        endcase
    end

    // Monitor: compares control outputs each cycle and the presented frame while valid.
    always @(negedge clk) begin
        bit     exp_rdy;
        bit     exp_mv;
        frame_t f;
        frame_t p;
        exp_rdy = !rst && (exp_q.size() < 2);
        exp_mv  = !rst && (exp_q.size() > 0);
        chk("s_ready", FW'(s_ready0), FW'(exp_rdy));
        chk("s_ready_br", FW'(s_ready1), FW'(exp_rdy));
        chk("m_valid", FW'(m_valid0), FW'(exp_mv));
        chk("m_valid_br", FW'(m_valid1), FW'(exp_mv));
        chk("frame_err", FW'(frame_err0), FW'(exp_err));
        chk("frame_err_br", FW'(frame_err1), FW'(exp_err));
        chk("frame_cnt", FW'(frame_cnt0), FW'(exp_cnt));
        chk("frame_cnt_br", FW'(frame_cnt1), FW'(exp_cnt));
        if (exp_mv) begin
            f = exp_q[0];
            for (int j = 0; j < 8; j++) begin
                p.re[W*j +: W] = f.re[W*brev(j) +: W];
                p.im[W*j +: W] = f.im[W*brev(j) +: W];
            end
            chk("m_re", m_re0, f.re);
            chk("m_im", m_im0, f.im);
            chk("m_re_br", m_re1, p.re);
            chk("m_im_br", m_im1, p.im);
            if (m_ready) f = exp_q.pop_front();
        end
    end

    task automatic do_reset(int n);
        @(posedge clk);
        #2;
        rst = 1'b1;
        stim.delete();
        repeat (n) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("m_re_after_reset", m_re0, '0);
        chk("m_im_after_reset", m_im1, '0);
    endtask

    task automatic drain(int budget);
        int c;
        c = 0;
        while ((stim.size() > 0 || exp_q.size() > 0) && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (c >= budget) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: %0d samples and %0d frames left after %0d cycles",
                     stim.size(), exp_q.size(), budget);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int k;
        bit last;
        do_reset(3);

        // Single ramp frame, consumer always ready.
        mr_mode = 1;
        for (int i = 0; i < 8; i++) push_samp(i + 1, -(i + 1), i == 7);
        drain(100);

        // Three back-to-back frames.
        for (int i = 0; i < 24; i++) push_samp($urandom, $urandom, (i % 8) == 7);
        drain(200);

        // Consumer stalled: both banks fill, input backs up, then drains in order.
        mr_mode = 0;
        for (int i = 0; i < 20; i++) push_samp($urandom, $urandom, (i % 8) == 7);
        repeat (40) @(posedge clk);
        mr_mode = 1;
        for (int i = 20; i < 24; i++) push_samp($urandom, $urandom, (i % 8) == 7);
        drain(200);

        // Early s_last on the 5th sample, then a good frame.
        for (int i = 0; i < 5; i++) push_samp(100 + i, -(100 + i), i == 4);
        for (int i = 0; i < 8; i++) push_samp(50 + i, 60 - i, i == 7);
        drain(200);

        // Missing s_last on the 8th sample: error pulse but frame delivered.
        for (int i = 0; i < 8; i++) push_samp(-20 - i, 7 * i, 1'b0);
        drain(200);

        // Reset with one frame held and a partial frame in flight.
        mr_mode = 0;
        for (int i = 0; i < 13; i++) push_samp($urandom, $urandom, i == 7);
        repeat (20) @(posedge clk);
        do_reset(2);
        mr_mode = 1;
        for (int i = 0; i < 8; i++) push_samp(3 * i - 9, 11 - i, i == 7);
        drain(200);

        // Random traffic with gaps, random back-pressure and occasional misaligned s_last.
        gaps    = 1'b1;
        mr_mode = 2;
        k       = 0;
        for (int i = 0; i < 300; i++) begin
            last = (k % 8) == 7;
            if ($urandom_range(15) == 0) last = !last;
            push_samp($urandom, $urandom, last);
            k = last ? 0 : k + 1;
        end
        drain(5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
